// File: rtl/graphics_pkg.sv
// Shared 720p timing constants, sprite table types and the scan FSM encoding
// used by the sprite scheduler and its line scanner.
package graphics_pkg;

  localparam int VID_WIDTH    = 1280;
  localparam int VID_HEIGHT   = 720;
  localparam int VID_H_TOTAL  = 1650;
  localparam int VID_V_TOTAL  = 750;
  localparam int SHEET_FRAMES = 512;

  localparam int X_W = $clog2(VID_WIDTH);
  localparam int Y_W = $clog2(VID_HEIGHT);
  localparam int F_W = $clog2(SHEET_FRAMES);
  localparam int N_W = 6;

  typedef struct packed {
    logic           enable;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [F_W-1:0] base_frame;
    logic [N_W-1:0] num_frames;
  } sprite_entry_t;

  // What the scanner needs per entry: position plus the resolved frame number.
  typedef struct packed {
    logic           enable;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [F_W-1:0] frame;
  } scan_entry_t;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_SCAN  = 2'd1,
    SCAN_LATCH = 2'd2
  } scan_state_t;

  // Animation length 0 behaves as a single-frame animation.
  function automatic logic [N_W-1:0] next_offset(input logic [N_W-1:0] off,
                                                 input logic [N_W-1:0] len);
    logic [N_W-1:0] eff;
    eff = (len == '0) ? N_W'(1) : len;
    return (off == eff - N_W'(1)) ? '0 : off + N_W'(1);
  endfunction

endpackage

// File: rtl/sprite_line_scanner.sv
// Per-line scan: in horizontal blanking walks the table snapshot one entry per
// cycle and latches the first enabled sprite covering the next line.
module sprite_line_scanner
  import graphics_pkg::*;
#(
  parameter int MAX_SPRITES         = 16,
  parameter int SPRITE_FRAME_HEIGHT = 64,
  parameter int WIDTH               = VID_WIDTH,
  parameter int HEIGHT              = VID_HEIGHT,
  parameter int V_TOTAL             = VID_V_TOTAL
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(WIDTH):0]         hcount,
  input  logic [$clog2(HEIGHT):0]        vcount,
  output logic [$clog2(MAX_SPRITES)-1:0] scan_index,
  input  scan_entry_t                    scan_entry,
  output logic                           sprite_valid,
  output logic [X_W-1:0]                 sprite_x,
  output logic [Y_W-1:0]                 sprite_y,
  output logic [F_W-1:0]                 sprite_frame_number,
  output scan_state_t                    state
);

  localparam int H_W   = $clog2(WIDTH) + 1;
  localparam int V_W   = $clog2(HEIGHT) + 1;
  localparam int IDX_W = $clog2(MAX_SPRITES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SPRITES - 1);

  scan_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [V_W-1:0] target_q;
  logic           hit_q;
  logic [X_W-1:0] hit_x_q;
  logic [Y_W-1:0] hit_y_q;
  logic [F_W-1:0] hit_f_q;

  logic           start;
  logic [V_W-1:0] entry_top;
  logic [V_W-1:0] entry_end;
  logic           entry_hit;

  assign start      = (state_q == SCAN_IDLE) && (hcount == H_W'(WIDTH));
  assign scan_index = idx_q;
  assign state      = state_q;

  // Bottom edge computed one bit wider than y so it never wraps; lines past
  // the active area never report a sprite.
  assign entry_top = V_W'(scan_entry.y);
  assign entry_end = entry_top + V_W'(SPRITE_FRAME_HEIGHT);
  assign entry_hit = scan_entry.enable && (target_q < V_W'(HEIGHT)) &&
                     (entry_top <= target_q) && (target_q < entry_end);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCAN_IDLE:  if (start) state_d = SCAN_SCAN;
      SCAN_SCAN:  if (idx_q == LAST_IDX) state_d = SCAN_LATCH;
      SCAN_LATCH: state_d = SCAN_IDLE;
      default:    state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= SCAN_IDLE;
      idx_q               <= '0;
      target_q            <= '0;
      hit_q               <= 1'b0;
      hit_x_q             <= '0;
      hit_y_q             <= '0;
      hit_f_q             <= '0;
      sprite_valid        <= 1'b0;
      sprite_x            <= '0;
      sprite_y            <= '0;
      sprite_frame_number <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        SCAN_IDLE: begin
          if (start) begin
            idx_q    <= '0;
            hit_q    <= 1'b0;
            target_q <= (vcount == V_W'(V_TOTAL - 1)) ? '0 : vcount + V_W'(1);
          end
        end
        SCAN_SCAN: begin
          idx_q <= idx_q + IDX_W'(1);
          if (entry_hit && !hit_q) begin
            hit_q   <= 1'b1;
            hit_x_q <= scan_entry.x;
            hit_y_q <= scan_entry.y;
            hit_f_q <= scan_entry.frame;
          end
        end
        SCAN_LATCH: begin
          sprite_valid <= hit_q;
          if (hit_q) begin
            sprite_x            <= hit_x_q;
            sprite_y            <= hit_y_q;
            sprite_frame_number <= hit_f_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Sprite table with frame-boundary commit and animation stepping; feeds the
// line scanner that picks one sprite per line for the HDMI renderer.
module sprite_scheduler
  import graphics_pkg::*;
#(
  parameter int MAX_SPRITES         = 16,
  parameter int NUM_FRAMES          = SHEET_FRAMES,
  parameter int SPRITE_FRAME_HEIGHT = 64,
  parameter int WIDTH               = VID_WIDTH,
  parameter int HEIGHT              = VID_HEIGHT,
  parameter int H_TOTAL             = VID_H_TOTAL,
  parameter int V_TOTAL             = VID_V_TOTAL,
  parameter int FRAMES_PER_STEP     = 6
) (
  input  logic                           clk_pixel,
  input  logic                           sys_rst,
  input  logic [$clog2(WIDTH):0]         hcount,
  input  logic [$clog2(HEIGHT):0]        vcount,
  input  logic                           new_frame,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [$clog2(MAX_SPRITES)-1:0] wr_index,
  input  logic                           wr_enable,
  input  logic [$clog2(WIDTH)-1:0]       wr_x,
  input  logic [$clog2(HEIGHT)-1:0]      wr_y,
  input  logic [$clog2(NUM_FRAMES)-1:0]  wr_base_frame,
  input  logic [5:0]                     wr_num_frames,
  output logic                           sprite_valid,
  output logic [$clog2(WIDTH)-1:0]       sprite_x,
  output logic [$clog2(HEIGHT)-1:0]      sprite_y,
  output logic [$clog2(NUM_FRAMES)-1:0]  sprite_frame_number
);

  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  if (MAX_SPRITES + 3 > H_TOTAL - WIDTH) begin : g_blank_check
    $error("sprite_scheduler: table scan does not fit in horizontal blanking");
  end

  sprite_entry_t        shadow_q [MAX_SPRITES];
  sprite_entry_t        active_q [MAX_SPRITES];
  logic [N_W-1:0]       offset_q [MAX_SPRITES];
  scan_entry_t          snap_q   [MAX_SPRITES];
  logic [MAX_SPRITES-1:0] dirty_q;
  logic [STEP_W-1:0]    step_q;
  logic                 step_wrap;
  logic                 wr_fire;

  logic [$clog2(MAX_SPRITES)-1:0] scan_index;
  scan_state_t          scan_state;

  // Handshake: a write is taken on any cycle with wr_valid && wr_ready.
  // wr_ready drops only during the commit (new_frame) cycle, so a request
  // held across it lands the following cycle and belongs to the next frame.
  assign wr_ready  = ~new_frame;
  assign wr_fire   = wr_valid & wr_ready;
  assign step_wrap = (step_q == STEP_W'(FRAMES_PER_STEP - 1));

  // Dirty marks entries written since the last commit; those restart their
  // animation at offset 0 instead of advancing.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        offset_q[i] <= '0;
      end
      dirty_q <= '0;
      step_q  <= '0;
    end else begin
      if (wr_fire) begin
        shadow_q[wr_index].enable     <= wr_enable;
        shadow_q[wr_index].x          <= wr_x;
        shadow_q[wr_index].y          <= wr_y;
        shadow_q[wr_index].base_frame <= wr_base_frame;
        shadow_q[wr_index].num_frames <= wr_num_frames;
        dirty_q[wr_index]             <= 1'b1;
      end
      if (new_frame) begin
        step_q  <= step_wrap ? '0 : step_q + STEP_W'(1);
        dirty_q <= '0;
        for (int i = 0; i < MAX_SPRITES; i++) begin
          active_q[i] <= shadow_q[i];
          if (dirty_q[i]) begin
            offset_q[i] <= '0;
          end else if (step_wrap && active_q[i].enable) begin
            offset_q[i] <= next_offset(offset_q[i], active_q[i].num_frames);
          end
        end
      end
    end
  end

  // Tracks the active table while the scanner idles and freezes at the trigger
  // edge, so a commit landing mid-scan only affects later scans.
  // Frame numbers wrap by truncation to the sheet index width.
  always_ff @(posedge clk_pixel) begin
    if (scan_state == SCAN_IDLE) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        snap_q[i].enable <= active_q[i].enable;
        snap_q[i].x      <= active_q[i].x;
        snap_q[i].y      <= active_q[i].y;
        snap_q[i].frame  <= active_q[i].base_frame + F_W'(offset_q[i]);
      end
    end
  end

  sprite_line_scanner #(
    .MAX_SPRITES         (MAX_SPRITES),
    .SPRITE_FRAME_HEIGHT (SPRITE_FRAME_HEIGHT),
    .WIDTH               (WIDTH),
    .HEIGHT              (HEIGHT),
    .V_TOTAL             (V_TOTAL)
  ) u_scanner (
    .clk                 (clk_pixel),
    .rst                 (sys_rst),
    .hcount              (hcount),
    .vcount              (vcount),
    .scan_index          (scan_index),
    .scan_entry          (snap_q[scan_index]),
    .sprite_valid        (sprite_valid),
    .sprite_x            (sprite_x),
    .sprite_y            (sprite_y),
    .sprite_frame_number (sprite_frame_number),
    .state               (scan_state)
  );

endmodule
